// File: rtl/tpg_pkg.sv
// tpg_pkg: shared modes, states, LFSR tap masks and pattern counts for the RCA pattern generator
package tpg_pkg;
  typedef enum logic [1:0] {MODE_CTEST, MODE_EXH, MODE_LFSR, MODE_RSVD} mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
  // Right-shift Galois masks: bit t-1 set for each feedback exponent t of a primitive polynomial
  function automatic logic [63:0] lfsr_taps(input int n);
    case (n)
      3: return 64'h6;
      4: return 64'hC;
      5: return 64'h14;
      6: return 64'h30;
      7: return 64'h60;
      8: return 64'hB8;
      9: return 64'h110;
      10: return 64'h240;
      11: return 64'h500;
      12: return 64'h829;
      13: return 64'h100D;
      14: return 64'h2015;
      15: return 64'h6000;
      16: return 64'hD008;
      17: return 64'h12000;
      18: return 64'h20400;
      19: return 64'h40023;
      20: return 64'h90000;
      21: return 64'h140000;
      22: return 64'h300000;
      23: return 64'h420000;
      24: return 64'hE10000;
      25: return 64'h1200000;
      26: return 64'h2000023;
      27: return 64'h4000013;
      28: return 64'h9000000;
      29: return 64'h14000000;
      30: return 64'h20000029;
      31: return 64'h48000000;
      32: return 64'h80200003;
      33: return 64'h100080000;
      default: return 64'h0;
    endcase
  endfunction
  function automatic logic [63:0] pat_count(input mode_e m, input int width, input int num_rand);
    return m == MODE_EXH ? 64'd1 << (2 * width + 1) : m == MODE_LFSR ? 64'(num_rand) : 64'd8;
  endfunction
endpackage

// File: rtl/tpg_rca_param_if.sv
// tpg_rca_param_if: controller-side handshake and adder-side pattern bus of the pattern generator
interface tpg_rca_param_if #(parameter int WIDTH = 5, parameter int IDXW = 17);
  logic start, hold, cin, valid, done, err;
  logic [1:0] mode;
  logic [WIDTH-1:0] a, b;
  logic [IDXW-1:0] pat_idx;
  modport master (output start, mode, hold, input a, b, cin, valid, pat_idx, done, err);
  modport slave (input start, mode, hold, output a, b, cin, valid, pat_idx, done, err);
endinterface

// File: rtl/tpg_lfsr.sv
// tpg_lfsr: N-bit right-shift Galois LFSR with synchronous load and step enable
module tpg_lfsr import tpg_pkg::*; #(
  parameter int N = 11,
  parameter logic [N-1:0] RST_V = 1
) (
  input  logic         clk,
  input  logic         init,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] seed,
  output logic [N-1:0] q
);
  localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));
  logic [N-1:0] q_q, q_d;
  always_comb q_d = load ? seed : step ? (q_q >> 1) ^ (q_q[0] ? TAPS : '0) : q_q;
  always_ff @(posedge clk or negedge init)
    if (!init) q_q <= RST_V;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/tpg_rca_param.sv
// tpg_rca_param: C-test / exhaustive / LFSR pattern generator for a WIDTH-bit ripple-carry adder
module tpg_rca_param import tpg_pkg::*; #(
  parameter int          WIDTH     = 5,
  parameter int          NUM_RAND  = 64,
  parameter logic [63:0] SEED      = 64'd1,
  parameter int          EXH_MAX_W = 8,
  parameter int          IDXW      = 17
) (
  input logic clk,
  input logic init,
  tpg_rca_param_if.slave bus
);
  localparam int N = 2 * WIDTH + 1;
  localparam logic [1:0] IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE;
  localparam logic [IDXW-1:0] LAST_CT = IDXW'(pat_count(MODE_CTEST, WIDTH, NUM_RAND) - 64'd1);
  localparam logic [IDXW-1:0] LAST_EX = IDXW'(pat_count(MODE_EXH, WIDTH, NUM_RAND) - 64'd1);
  localparam logic [IDXW-1:0] LAST_RN = IDXW'(pat_count(MODE_LFSR, WIDTH, NUM_RAND) - 64'd1);
  logic [1:0] state_q, state_d;
  mode_e mode_q, mode_d;
  logic [IDXW-1:0] idx_q, idx_d, last_idx;
  logic [N-1:0] pat_q, pat_d, lfsr_q;
  logic valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic legal, go, accept, is_last, ao, bo;
  logic [2:0] d;
  logic [WIDTH-1:0] ct_a, ct_b;
  always_comb begin
    legal = bus.mode != MODE_RSVD && !(bus.mode == MODE_EXH && WIDTH > EXH_MAX_W);
    go = state_q == IDLE && bus.start && legal;
    accept = valid_q && !bus.hold;
    last_idx = mode_q == MODE_CTEST ? LAST_CT : mode_q == MODE_EXH ? LAST_EX : LAST_RN;
    is_last = idx_q == last_idx;
    state_d = go ? RUN : accept && is_last ? DONE : state_q == DONE ? IDLE : state_q;
    mode_d = go ? mode_e'(bus.mode) : mode_q;
    idx_d = go ? '0 : accept && !is_last ? idx_q + 1'b1 : idx_q;
    valid_d = go || (valid_q && !(accept && is_last));
    done_d = accept && is_last;
    err_d = state_q == IDLE && bus.start && !legal;
  end
  // C-test cell inputs: cell 0 takes the raw bits, odd cells the carry-restoring pair
  always_comb begin
    d = idx_d[2:0];
    ao = (~d[1] & (d[2] | d[0])) | (d[2] & d[0]);
    bo = (~d[0] & (d[2] | d[1])) | (d[2] & d[1]);
    ct_a = '0;
    ct_b = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ct_a[i] = i == 0 ? d[2] : i % 2 == 1 ? ao : d[1];
      ct_b[i] = i == 0 ? d[1] : i % 2 == 1 ? bo : d[0];
    end
    pat_d = mode_d == MODE_EXH ? N'(idx_d) : {ct_a, ct_b, d[0]};
  end
  always_ff @(posedge clk or negedge init)
    if (!init) begin
      state_q <= IDLE;
      mode_q <= MODE_CTEST;
      idx_q <= '0;
      pat_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      idx_q <= idx_d;
      pat_q <= pat_d;
      valid_q <= valid_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  tpg_lfsr #(.N(N), .RST_V(N'(SEED))) u_lfsr (
    .clk(clk), .init(init), .load(go), .step(accept), .seed(N'(SEED)), .q(lfsr_q)
  );
  // LFSR state is itself a register, so it drives the pattern bus directly in LFSR mode
  assign {bus.a, bus.b, bus.cin} = mode_q == MODE_LFSR ? lfsr_q : pat_q;
  assign bus.valid = valid_q;
  assign bus.pat_idx = idx_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_tpg_rca_param.sv
// tb_tpg_rca_param: directed-vector bench for tpg_rca_param at WIDTH 5, 2 and 9
module tb_tpg_rca_param;
  logic clk = 1'b0;
  logic init = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  tpg_rca_param_if #(.WIDTH(5), .IDXW(17)) if5 ();
  tpg_rca_param_if #(.WIDTH(2), .IDXW(17)) if2 ();
  tpg_rca_param_if #(.WIDTH(9), .IDXW(17)) if9 ();
  tpg_rca_param #(.WIDTH(5), .NUM_RAND(64), .SEED(64'd1), .EXH_MAX_W(8), .IDXW(17)) u5 (
    .clk(clk), .init(init), .bus(if5.slave));
  tpg_rca_param #(.WIDTH(2), .NUM_RAND(64), .SEED(64'd1), .EXH_MAX_W(8), .IDXW(17)) u2 (
    .clk(clk), .init(init), .bus(if2.slave));
  tpg_rca_param #(.WIDTH(9), .NUM_RAND(64), .SEED(64'd1), .EXH_MAX_W(8), .IDXW(17)) u9 (
    .clk(clk), .init(init), .bus(if9.slave));
  // {a,b,cin} for C-test index 0..7 at WIDTH=5, hand-derived from the cell equations
  logic [10:0] ct_exp [8] = '{
    11'b00000_00000_0, 11'b01010_10100_1, 11'b10100_01011_0, 11'b10100_10101_1,
    11'b01011_01010_0, 11'b01011_10100_1, 11'b10101_01011_0, 11'b11111_11111_1};
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic test_reset;
    #1 init = 1'b0;
    #2;
    vectors++;
    if ({if5.a, if5.b, if5.cin, if5.valid, if5.pat_idx, if5.done, if5.err} !== 31'd0) begin
      miscompares++;
      $display("FAIL reset5 got %h exp 0", {if5.a, if5.b, if5.cin, if5.valid, if5.pat_idx, if5.done, if5.err});
    end
    vectors++;
    if ({if2.a, if2.b, if2.cin, if2.valid, if2.done, if2.err} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset2 got %h exp 0", {if2.a, if2.b, if2.cin, if2.valid, if2.done, if2.err});
    end
    tick;
    tick;
    init = 1'b1;
    tick;
    vectors++;
    if ({if5.valid, if5.done, if5.err, if5.pat_idx} !== 20'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset got %h exp 0", {if5.valid, if5.done, if5.err, if5.pat_idx});
    end
  endtask
  task automatic test_ctest;
    if5.start = 1'b1;
    if5.mode = 2'd0;
    tick;
    if5.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if ({if5.valid, if5.done, if5.pat_idx, if5.a, if5.b, if5.cin} !== {1'b1, 1'b0, 17'(k), ct_exp[k]}) begin
        miscompares++;
        $display("FAIL ctest[%0d] got v=%b d=%b idx=%0d abc=%b exp abc=%b", k, if5.valid, if5.done,
                 if5.pat_idx, {if5.a, if5.b, if5.cin}, ct_exp[k]);
      end
      tick;
    end
    vectors++;
    if ({if5.valid, if5.done} !== 2'b01) begin
      miscompares++;
      $display("FAIL ctest_done got v=%b d=%b exp v=0 d=1", if5.valid, if5.done);
    end
    tick;
    vectors++;
    if ({if5.valid, if5.done} !== 2'b00) begin
      miscompares++;
      $display("FAIL ctest_done_pulse got v=%b d=%b exp 0 0", if5.valid, if5.done);
    end
  endtask
  task automatic test_hold;
    int k = 0;
    int hcnt = 0;
    int seen4 = 0;
    if5.start = 1'b1;
    if5.mode = 2'd0;
    tick;
    if5.start = 1'b0;
    for (int c = 0; c < 11; c++) begin
      vectors++;
      if ({if5.valid, if5.done, if5.pat_idx, if5.a, if5.b, if5.cin} !== {1'b1, 1'b0, 17'(k), ct_exp[k]}) begin
        miscompares++;
        $display("FAIL hold_cyc[%0d] got v=%b d=%b idx=%0d abc=%b exp idx=%0d abc=%b", c, if5.valid,
                 if5.done, if5.pat_idx, {if5.a, if5.b, if5.cin}, k, ct_exp[k]);
      end
      if (if5.pat_idx == 17'd4) seen4++;
      if5.hold = k == 4 && hcnt < 3;
      if (if5.hold) hcnt++;
      else k++;
      tick;
    end
    if5.hold = 1'b0;
    vectors++;
    if (seen4 != 4) begin
      miscompares++;
      $display("FAIL hold_stable got %0d cycles exp 4", seen4);
    end
    vectors++;
    if ({if5.valid, if5.done} !== 2'b01) begin
      miscompares++;
      $display("FAIL hold_done got v=%b d=%b exp v=0 d=1", if5.valid, if5.done);
    end
    tick;
  endtask
  task automatic test_exh;
    if2.start = 1'b1;
    if2.mode = 2'd1;
    tick;
    if2.start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      vectors++;
      if ({if2.valid, if2.done, if2.pat_idx, if2.a, if2.b, if2.cin} !== {1'b1, 1'b0, 17'(k), 5'(k)}) begin
        miscompares++;
        $display("FAIL exh[%0d] got v=%b d=%b idx=%0d abc=%b", k, if2.valid, if2.done, if2.pat_idx,
                 {if2.a, if2.b, if2.cin});
      end
      tick;
    end
    vectors++;
    if ({if2.valid, if2.done} !== 2'b01) begin
      miscompares++;
      $display("FAIL exh_done got v=%b d=%b exp v=0 d=1", if2.valid, if2.done);
    end
    tick;
    vectors++;
    if ({if2.valid, if2.done} !== 2'b00) begin
      miscompares++;
      $display("FAIL exh_done_pulse got v=%b d=%b exp 0 0", if2.valid, if2.done);
    end
  endtask
  task automatic test_lfsr;
    logic [10:0] s;
    for (int r = 0; r < 2; r++) begin
      s = 11'h001;
      if5.start = 1'b1;
      if5.mode = 2'd2;
      tick;
      if5.start = 1'b0;
      for (int k = 0; k < 64; k++) begin
        vectors++;
        if ({if5.valid, if5.done, if5.pat_idx, if5.a, if5.b, if5.cin} !== {1'b1, 1'b0, 17'(k), s} ||
            {if5.a, if5.b, if5.cin} == 11'd0) begin
          miscompares++;
          $display("FAIL lfsr_run%0d[%0d] got v=%b idx=%0d abc=%h exp %h", r, k, if5.valid, if5.pat_idx,
                   {if5.a, if5.b, if5.cin}, s);
        end
        if5.start = r == 1 && k == 10;
        if5.mode = if5.start ? 2'd0 : 2'd2;
        s = s[0] ? (s >> 1) ^ 11'h500 : s >> 1;
        tick;
      end
      if5.start = 1'b0;
      vectors++;
      if ({if5.valid, if5.done} !== 2'b01) begin
        miscompares++;
        $display("FAIL lfsr_done%0d got v=%b d=%b exp v=0 d=1", r, if5.valid, if5.done);
      end
      tick;
    end
  endtask
  task automatic test_err;
    if5.start = 1'b1;
    if5.mode = 2'd3;
    tick;
    if5.start = 1'b0;
    vectors++;
    if ({if5.err, if5.valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL err_mode3 got err=%b v=%b exp err=1 v=0", if5.err, if5.valid);
    end
    tick;
    vectors++;
    if ({if5.err, if5.valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL err_pulse got err=%b v=%b exp 0 0", if5.err, if5.valid);
    end
    if9.start = 1'b1;
    if9.mode = 2'd1;
    tick;
    if9.start = 1'b0;
    vectors++;
    if ({if9.err, if9.valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL err_exh_w9 got err=%b v=%b exp err=1 v=0", if9.err, if9.valid);
    end
    tick;
    vectors++;
    if ({if9.err, if9.valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL err_w9_pulse got err=%b v=%b exp 0 0", if9.err, if9.valid);
    end
    if9.start = 1'b1;
    if9.mode = 2'd0;
    tick;
    if9.start = 1'b0;
    vectors++;
    if ({if9.err, if9.valid, if9.pat_idx, if9.a, if9.b, if9.cin} !== {1'b0, 1'b1, 17'd0, 19'd0}) begin
      miscompares++;
      $display("FAIL w9_ctest_start got err=%b v=%b idx=%0d abc=%h exp 0 1 0 0", if9.err, if9.valid,
               if9.pat_idx, {if9.a, if9.b, if9.cin});
    end
  endtask
  task automatic test_reset_midrun;
    if5.start = 1'b1;
    if5.mode = 2'd0;
    tick;
    if5.start = 1'b0;
    tick;
    tick;
    tick;
    vectors++;
    if ({if5.valid, if5.pat_idx, if5.a, if5.b, if5.cin} !== {1'b1, 17'd3, ct_exp[3]}) begin
      miscompares++;
      $display("FAIL midrun_pat3 got v=%b idx=%0d abc=%b", if5.valid, if5.pat_idx, {if5.a, if5.b, if5.cin});
    end
    #2 init = 1'b0;
    #1;
    vectors++;
    if ({if5.a, if5.b, if5.cin, if5.valid, if5.pat_idx, if5.done, if5.err} !== 31'd0) begin
      miscompares++;
      $display("FAIL async_reset got %h exp 0", {if5.a, if5.b, if5.cin, if5.valid, if5.pat_idx, if5.done, if5.err});
    end
    tick;
    tick;
    init = 1'b1;
    tick;
    vectors++;
    if ({if5.valid, if5.done} !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_no_done got v=%b d=%b exp 0 0", if5.valid, if5.done);
    end
    if5.start = 1'b1;
    tick;
    if5.start = 1'b0;
    vectors++;
    if ({if5.valid, if5.pat_idx, if5.a, if5.b, if5.cin} !== {1'b1, 17'd0, ct_exp[0]}) begin
      miscompares++;
      $display("FAIL restart_pat0 got v=%b idx=%0d abc=%b", if5.valid, if5.pat_idx, {if5.a, if5.b, if5.cin});
    end
    for (int k = 0; k < 8; k++) tick;
    vectors++;
    if ({if5.valid, if5.done} !== 2'b01) begin
      miscompares++;
      $display("FAIL restart_done got v=%b d=%b exp v=0 d=1", if5.valid, if5.done);
    end
  endtask
  initial begin
    if5.start = 1'b0;
    if5.hold = 1'b0;
    if5.mode = 2'd0;
    if2.start = 1'b0;
    if2.hold = 1'b0;
    if2.mode = 2'd0;
    if9.start = 1'b0;
    if9.hold = 1'b0;
    if9.mode = 2'd0;
    test_reset;
    test_ctest;
    test_hold;
    test_exh;
    test_lfsr;
    test_err;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
